// File: rtl/vc_fifo_if.sv
// Write/read handshake bundle for the multi-VC input buffer.
// The router-side producer/consumer uses master; the buffer uses slave.
interface vc_fifo_if #(
  parameter int DATA_WIDTH = 12,
  parameter int VC_W       = 2
);
  logic                  wr_en;
  logic [VC_W-1:0]       wr_vc;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [VC_W-1:0]       rd_vc;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output wr_en, wr_vc, wr_data, rd_en, rd_vc,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_vc, wr_data, rd_en, rd_vc,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/vc_fifo.sv
// Multi-virtual-channel input buffer: NUM_VC statically partitioned FIFOs
// sharing one storage array, with per-VC status and sticky error flags.
module vc_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_VC     = 4,
  parameter int VC_W       = 2,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  vc_fifo_if.slave                         bus,
  output logic [NUM_VC-1:0]                full,
  output logic [NUM_VC-1:0]                empty,
  output logic [NUM_VC-1:0]                almost_full,
  output logic [NUM_VC*(ADDR_WIDTH+1)-1:0] count,
  output logic                             err_overflow,
  output logic                             err_underflow,
  input  logic                             err_clr
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int MW = VC_W + ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NUM_VC*DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q [NUM_VC];
  logic [ADDR_WIDTH-1:0] wr_ptr_d [NUM_VC];
  logic [ADDR_WIDTH-1:0] rd_ptr_q [NUM_VC];
  logic [ADDR_WIDTH-1:0] rd_ptr_d [NUM_VC];
  logic [CW-1:0]         cnt_q    [NUM_VC];
  logic [CW-1:0]         cnt_d    [NUM_VC];

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_udf_q, err_udf_d;

  logic                  rd_accept, wr_accept;
  logic [MW-1:0]         wr_addr, rd_addr;
  logic [NUM_VC-1:0]     wr_hit, rd_hit;

  always_comb begin
    full        = '0;
    empty       = '0;
    almost_full = '0;
    count       = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      full[v]             = (cnt_q[v] == CW'(DEPTH));
      empty[v]            = (cnt_q[v] == '0);
      almost_full[v]      = (cnt_q[v] >= CW'(AF_THRESH));
      count[v*CW +: CW]   = cnt_q[v];
    end
  end

  // A full VC still accepts a write when the same VC is read this cycle;
  // reads never see a same-cycle write (no bypass into an empty VC).
  always_comb begin
    rd_accept = bus.rd_en && !empty[bus.rd_vc];
    wr_accept = bus.wr_en &&
                (!full[bus.wr_vc] || (rd_accept && (bus.rd_vc == bus.wr_vc)));
    wr_addr   = {bus.wr_vc, wr_ptr_q[bus.wr_vc]};
    rd_addr   = {bus.rd_vc, rd_ptr_q[bus.rd_vc]};
  end

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      wr_hit[v]   = wr_accept && (bus.wr_vc == VC_W'(v));
      rd_hit[v]   = rd_accept && (bus.rd_vc == VC_W'(v));
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      cnt_d[v]    = cnt_q[v];
      if (wr_hit[v]) wr_ptr_d[v] = wr_ptr_q[v] + ADDR_WIDTH'(1);
      if (rd_hit[v]) rd_ptr_d[v] = rd_ptr_q[v] + ADDR_WIDTH'(1);
      if (wr_hit[v] && !rd_hit[v]) cnt_d[v] = cnt_q[v] + CW'(1);
      if (rd_hit[v] && !wr_hit[v]) cnt_d[v] = cnt_q[v] - CW'(1);
    end
  end

  always_comb begin
    rd_valid_d = rd_accept;
    rd_data_d  = rd_accept ? mem_q[rd_addr] : rd_data_q;
    err_ovf_d  = err_clr ? 1'b0 : (err_ovf_q | (bus.wr_en && !wr_accept));
    err_udf_d  = err_clr ? 1'b0 : (err_udf_q | (bus.rd_en && !rd_accept));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_udf_q  <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
      end
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_ovf_q  <= err_ovf_d;
      err_udf_q  <= err_udf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_addr] <= bus.wr_data;
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_udf_q;
endmodule

// File: tb/tb_vc_fifo.sv
// Self-checking bench for vc_fifo: directed table, corner sequences and
// random traffic against a per-VC queue reference model.
module tb_vc_fifo;
  localparam int DW = 12, NV = 4, VW = 2, AW = 3, DEPTH = 8, AF = 6, CW = AW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              err_clr;
  logic [NV-1:0]     full, empty, almost_full;
  logic [NV*CW-1:0]  count;
  logic              err_overflow, err_underflow;

  always #5 clk = ~clk;

  vc_fifo_if #(.DATA_WIDTH(DW), .VC_W(VW)) bus ();

  vc_fifo #(
    .DATA_WIDTH(DW), .NUM_VC(NV), .VC_W(VW),
    .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AF_THRESH(AF)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_clr(err_clr)
  );

  // Reference model: one queue per VC plus the registered read outputs.
  logic [DW-1:0] mq [NV][$];
  logic [DW-1:0] m_data;
  logic          m_valid, m_ovf, m_udf;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic          we;
    logic [VW-1:0] wv;
    logic [DW-1:0] wd;
    logic          re;
    logic [VW-1:0] rv;
    logic          clr;
    logic          ev;
    logic [DW-1:0] ed;
    logic [NV-1:0] ee;
    logic          eudf;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) mq[v].delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic compare_all();
    logic [NV*CW-1:0] ec;
    logic [NV-1:0]    ef, ee, ea;
    int               n;
    ec = '0; ef = '0; ee = '0; ea = '0;
    for (int v = 0; v < NV; v++) begin
      n = mq[v].size();
      ec[v*CW +: CW] = CW'(n);
      ef[v] = (n == DEPTH);
      ee[v] = (n == 0);
      ea[v] = (n >= AF);
    end
    check("count",       32'(count),         32'(ec));
    check("full",        32'(full),          32'(ef));
    check("empty",       32'(empty),         32'(ee));
    check("almost_full", 32'(almost_full),   32'(ea));
    check("rd_valid",    32'(bus.rd_valid),  32'(m_valid));
    check("rd_data",     32'(bus.rd_data),   32'(m_data));
    check("err_ovf",     32'(err_overflow),  32'(m_ovf));
    check("err_udf",     32'(err_underflow), 32'(m_udf));
  endtask

  task automatic step(input logic we, input logic [VW-1:0] wv, input logic [DW-1:0] wd,
                      input logic re, input logic [VW-1:0] rv, input logic clr);
    bit rd_ok, wr_ok;
    bus.wr_en = we; bus.wr_vc = wv; bus.wr_data = wd;
    bus.rd_en = re; bus.rd_vc = rv; err_clr = clr;
    rd_ok = re && (mq[rv].size() > 0);
    wr_ok = we && ((mq[wv].size() < DEPTH) || (rd_ok && (rv == wv)));
    @(posedge clk);
    #1;
    m_valid = rd_ok;
    if (rd_ok) m_data = mq[rv].pop_front();
    if (wr_ok) mq[wv].push_back(wd);
    m_ovf = clr ? 1'b0 : (m_ovf | (we && !wr_ok));
    m_udf = clr ? 1'b0 : (m_udf | (re && !rd_ok));
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 2'd0, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0, 12'h000, 4'b1111, 1'b0};
    tbl[1] = '{1'b1, 2'd3, 12'h055, 1'b1, 2'd3, 1'b0, 1'b0, 12'h000, 4'b0111, 1'b1};
    tbl[2] = '{1'b0, 2'd0, 12'h000, 1'b1, 2'd3, 1'b0, 1'b1, 12'h055, 4'b1111, 1'b1};
    tbl[3] = '{1'b0, 2'd0, 12'h000, 1'b0, 2'd0, 1'b1, 1'b0, 12'h055, 4'b1111, 1'b0};
    tbl[4] = '{1'b1, 2'd0, 12'h111, 1'b1, 2'd1, 1'b0, 1'b0, 12'h055, 4'b1110, 1'b1};
    tbl[5] = '{1'b1, 2'd1, 12'h222, 1'b1, 2'd0, 1'b0, 1'b1, 12'h111, 4'b1101, 1'b1};
    tbl[6] = '{1'b0, 2'd0, 12'h000, 1'b1, 2'd1, 1'b1, 1'b1, 12'h222, 4'b1111, 1'b0};
    tbl[7] = '{1'b0, 2'd0, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0, 12'h222, 4'b1111, 1'b0};

    rst = 1'b0; err_clr = 1'b0;
    bus.wr_en = 1'b0; bus.wr_vc = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_vc = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    // Directed table starting from the reset state
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].we, tbl[i].wv, tbl[i].wd, tbl[i].re, tbl[i].rv, tbl[i].clr);
      check("tbl_valid", 32'(bus.rd_valid),  32'(tbl[i].ev));
      check("tbl_data",  32'(bus.rd_data),   32'(tbl[i].ed));
      check("tbl_empty", 32'(empty),         32'(tbl[i].ee));
      check("tbl_udf",   32'(err_underflow), 32'(tbl[i].eudf));
    end

    // VC2 fill then drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 2'd2, DW'(i), 1'b0, '0, 1'b0);
      if (i == 5) check("vc2_af_at5", 32'(almost_full[2]), 32'd0);
      if (i == 6) check("vc2_af_at6", 32'(almost_full[2]), 32'd1);
      if (i == 7) check("vc2_nfull7", 32'(full[2]), 32'd0);
    end
    check("vc2_full", 32'(full[2]), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0, '0, 1'b1, 2'd2, 1'b0);
      check("vc2_rd_valid", 32'(bus.rd_valid), 32'd1);
      check("vc2_rd_data",  32'(bus.rd_data),  32'(i));
    end
    check("vc2_empty", 32'(empty[2]), 32'd1);

    // VC1 overflow and error clear
    for (int i = 0; i < 8; i++) step(1'b1, 2'd1, DW'(12'h100 + i), 1'b0, '0, 1'b0);
    step(1'b1, 2'd1, 12'h0AA, 1'b0, '0, 1'b0);
    check("ovf_flag",  32'(err_overflow), 32'd1);
    check("ovf_count", 32'(count[1*CW +: CW]), 32'd8);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1);
    check("ovf_clr", 32'(err_overflow), 32'd0);
    // clear wins over a same-cycle drop
    step(1'b1, 2'd1, 12'h0BB, 1'b0, '0, 1'b1);
    check("ovf_clr_prio", 32'(err_overflow), 32'd0);

    // VC0 full with a same-cycle write and read
    for (int i = 1; i <= 8; i++) step(1'b1, 2'd0, DW'(12'h300 + i), 1'b0, '0, 1'b0);
    step(1'b1, 2'd0, 12'h123, 1'b1, 2'd0, 1'b0);
    check("wr_rd_full_data",  32'(bus.rd_data), 32'h301);
    check("wr_rd_full_count", 32'(count[0 +: CW]), 32'd8);
    check("wr_rd_full_ovf",   32'(err_overflow), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 2'd0, 1'b0);
    check("vc0_last", 32'(bus.rd_data), 32'h123);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 2'd1, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 60), VW'($urandom_range(0, NV - 1)), DW'($urandom),
           ($urandom_range(0, 99) < 50), VW'($urandom_range(0, NV - 1)),
           ($urandom_range(0, 99) < 4));
    end

    // Interleaved VC0/VC1 traffic, then reset mid-stream
    for (int i = 0; i < 20; i++) begin
      step(1'b1, VW'(i % 2), DW'(12'h400 + i), 1'b1, VW'((i + 1) % 2), 1'b0);
    end
    step(1'b1, 2'd3, 12'h777, 1'b0, '0, 1'b0);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; err_clr = 1'b0;
    #3 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_empty", 32'(empty), 32'hF);
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0, '0, '0, 1'b1, 2'd3, 1'b0);
    check("post_rst_udf",   32'(err_underflow), 32'd1);
    check("post_rst_valid", 32'(bus.rd_valid),  32'd0);
    step(1'b0, '0, '0, 1'b1, 2'd0, 1'b1);
    check("post_rst_clr", 32'(err_underflow), 32'd0);
    step(1'b0, '0, '0, 1'b1, 2'd1, 1'b0);
    check("post_rst_udf1", 32'(err_underflow), 32'd1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
- Multi-virtual-channel synchronous input buffer for the NoC router input port.
- NUM_VC independent FIFOs share one flat storage array. Each VC is a statically partitioned region of DEPTH entries.
- One write port and one read port, each steered by a VC index.
- Per-VC full, empty, almost-full and occupancy status feed the VC allocator and credit logic.
- Overflow and underflow are trapped and reported through sticky error flags.

Parameters:
- DATA_WIDTH, 12, flit width in bits
- NUM_VC, 4, number of virtual channels
- VC_W, 2, VC index width; equals log2(NUM_VC)
- ADDR_WIDTH, 3, per-VC pointer width
- DEPTH, 8, entries per VC; must equal 2**ADDR_WIDTH
- AF_THRESH, 6, almost_full asserts when a VC's count is at or above this value

Ports:
- clk, in, 1, clock; all state updates on the rising edge
- rst, in, 1, asynchronous, active-low reset
- wr_en, in, 1, write request
- wr_vc, in, VC_W, target VC for the write
- wr_data, in, DATA_WIDTH, flit to write
- rd_en, in, 1, read request
- rd_vc, in, VC_W, source VC for the read
- rd_data, out, DATA_WIDTH, registered read data
- rd_valid, out, 1, one-cycle pulse: rd_data was updated by the previous edge
- full, out, NUM_VC, per-VC full flag; bit v set when count[v]==DEPTH
- empty, out, NUM_VC, per-VC empty flag; bit v set when count[v]==0
- almost_full, out, NUM_VC, per-VC flag; bit v set when count[v]>=AF_THRESH
- count, out, NUM_VC*(ADDR_WIDTH+1), per-VC occupancy; VC v occupies bits [v*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]
- err_overflow, out, 1, sticky flag: a write to a full VC was dropped
- err_underflow, out, 1, sticky flag: a read of an empty VC was dropped
- err_clr, in, 1, synchronous clear for both error flags

Behaviour:
- Reset (rst low, asynchronous), all of the following are forced:
  - all write and read pointers = 0, all counts = 0
  - rd_data = 0, rd_valid = 0, err_overflow = 0, err_underflow = 0
  - hence empty = all ones, full = 0, almost_full = 0
  - storage contents are not reset
- Reset asserted mid-operation discards all queued flits. The first edge after release sees all VCs empty.
- Storage address is {vc, ptr}; total storage is NUM_VC*DEPTH entries.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Write accepted when wr_en is high and (full[wr_vc]==0, or a read of the same VC is accepted in the same cycle):
  - mem[{wr_vc, wr_ptr[wr_vc]}] <= wr_data
  - wr_ptr[wr_vc] increments
- Write dropped when wr_en is high, full[wr_vc] is set, and there is no same-VC accepted read:
  - no state changes
  - err_overflow <= 1
- Read accepted when rd_en is high and empty[rd_vc]==0, with status sampled before the edge:
  - rd_data <= mem[{rd_vc, rd_ptr[rd_vc]}]
  - rd_ptr[rd_vc] increments
  - rd_valid <= 1 for exactly one cycle
- Read latency: data is visible one edge after the request.
- Read dropped when rd_en is high and empty[rd_vc] is set:
  - rd_valid <= 0, rd_data holds its value
  - err_underflow <= 1
  - There is no write-to-read bypass: a same-cycle write to an empty VC does not satisfy that read.
- rd_data holds its last value whenever no read is accepted.
- Count update per VC v, per cycle:
  - +1 on an accepted write only
  - -1 on an accepted read only
  - unchanged when both are accepted on v, or neither
- Writes and reads on different VCs in the same cycle are fully independent.
- full, empty and almost_full are combinational decodes of the count registers.
- Error flags:
  - err_clr has priority over a same-cycle set; the flag reads 0 after that edge.
  - Flags otherwise hold until reset.

Test Plan:
- Reset, then idle -> empty=4'b1111, full=0, rd_valid=0, rd_data=0, all counts 0.
- Write 0x001..0x008 to VC2, then 8 reads of VC2 -> full[2]=1 after the 8th write; almost_full[2]=1 from count 6; reads return 0x001..0x008 in order, each one cycle after its rd_en; empty[2]=1 at the end.
- Fill VC1 to 8, write 0x0AA to VC1 -> write dropped, count stays 8, err_overflow=1. Pulse err_clr -> err_overflow=0.
- Read VC3 while empty, simultaneously writing 0x055 to VC3 -> rd_valid=0, err_underflow=1, count[VC3]=1. Next read returns 0x055.
- VC0 full, same-cycle write 0x123 and read of VC0 -> read returns the oldest flit, count stays 8. Drain 8 -> 0x123 appears last.
- Interleave writes to VC0 and reads from VC1 over 20 cycles with pointer wrap; assert rst mid-stream -> all counts 0 immediately, and post-reset reads of any VC set err_underflow.
